// File: rtl/ext_mem_loader.sv
// Sequencer: streams a program into instruction memory, runs the CPU for a fixed cycle count, then streams data memory out.
// Latency: LOAD 1 word/cycle, RUN exactly run_cycles, DUMP 3 cycles/word minimum; out_valid holds under out_ready backpressure.
// Backpressure: in_ready only in LOAD; out_valid/out_data held until out_ready.
module ext_mem_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [9:0]  prog_len,
    input  logic [31:0] run_cycles,
    input  logic [10:0] dump_len,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        cpu_enable,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [9:0]  r_prog_len;
    logic [31:0] r_run_len;
    logic [10:0] r_dump_len;
    logic [10:0] r_wc;
    logic [31:0] r_cyc;
    logic [31:0] r_out_data;

    logic [9:0]  w_prog_clamp;
    logic [10:0] w_dump_clamp;
    logic        w_start_ok;
    logic        w_load_xfer;
    logic [10:0] w_wc_inc;
    logic [31:0] w_cyc_inc;

    assign w_prog_clamp = (32'(prog_len) > 32'(IMEM_DEPTH)) ? 10'(IMEM_DEPTH) : prog_len;
    assign w_dump_clamp = (32'(dump_len) > 32'(DMEM_DEPTH)) ? 11'(DMEM_DEPTH) : dump_len;
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_load_xfer  = (r_state == S_LOAD) && in_valid;
    assign w_wc_inc     = r_wc + 11'd1;
    assign w_cyc_inc    = r_cyc + 32'd1;

    // Zero-length phases are skipped; only the first nonzero phase after the current one is entered.
    function automatic state_t next_after_load(input logic [31:0] run_len, input logic [10:0] dlen);
        state_t nxt;
        nxt = S_DONE;
        if (run_len != 32'd0) begin
            nxt = S_RUN;
        end else if (dlen != 11'd0) begin
            nxt = S_DUMP_RD;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_prog_len <= '0;
            r_run_len  <= '0;
            r_dump_len <= '0;
            r_wc       <= '0;
            r_cyc      <= '0;
            r_out_data <= '0;
        end else if (w_start_ok) begin
            r_prog_len <= w_prog_clamp;
            r_run_len  <= run_cycles;
            r_dump_len <= w_dump_clamp;
            r_wc       <= '0;
            r_cyc      <= '0;
            r_state    <= (w_prog_clamp != 10'd0) ? S_LOAD
                                                  : next_after_load(run_cycles, w_dump_clamp);
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_wc <= w_wc_inc;
                        if (w_wc_inc == {1'b0, r_prog_len}) begin
                            r_wc    <= '0;
                            r_state <= next_after_load(r_run_len, r_dump_len);
                        end
                    end
                end
                S_RUN: begin
                    r_cyc <= w_cyc_inc;
                    if (w_cyc_inc == r_run_len) begin
                        r_wc    <= '0;
                        r_state <= (r_dump_len != 11'd0) ? S_DUMP_RD : S_DONE;
                    end
                end
                S_DUMP_RD: begin
                    r_state <= S_DUMP_WAIT;
                end
                S_DUMP_WAIT: begin
                    r_out_data <= rdata_ext_2;
                    r_state    <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (out_ready) begin
                        r_wc    <= w_wc_inc;
                        r_state <= (w_wc_inc == r_dump_len) ? S_DONE : S_DUMP_RD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All strobes decode directly from the state register so reset silences them at once.
    assign in_ready    = (r_state == S_LOAD);
    assign wen_ext     = w_load_xfer;
    assign wdata_ext   = w_load_xfer ? in_data : 32'd0;
    assign addr_ext    = (r_state == S_LOAD) ? {19'd0, r_wc, 2'b00} : 32'd0;
    assign ren_ext     = 1'b0;
    assign cpu_enable  = (r_state == S_RUN);
    assign ren_ext_2   = (r_state == S_DUMP_RD);
    assign addr_ext_2  = (r_state == S_DUMP_RD) ? {19'd0, r_wc, 2'b00} : 32'd0;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = 32'd0;
    assign out_valid   = (r_state == S_DUMP_OUT);
    assign out_data    = r_out_data;
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);

endmodule
